// File: rtl/alu_pkg.sv
// Shared ALU definitions: op classes, flag bit positions and opcode widths.
package alu_pkg;
   localparam int SHIFT_OPCODE_WIDTH = 2;
   localparam int LOGIC_OPCODE_WIDTH = 3;

   typedef enum logic [2:0] {
      OP_ADD   = 3'd0,
      OP_SUB   = 3'd1,
      OP_ADC   = 3'd2,
      OP_SBC   = 3'd3,
      OP_SHIFT = 3'd4,
      OP_LOGIC = 3'd5,
      OP_CMP   = 3'd6,
      OP_RSVD  = 3'd7
   } alu_op_class_e;

   // Bit positions within the {N,Z,C,V} flag vector
   localparam int FLAG_N = 3;
   localparam int FLAG_Z = 2;
   localparam int FLAG_C = 1;
   localparam int FLAG_V = 0;

   // Classes whose carry/overflow are architecturally meaningful
   function automatic logic op_uses_carry(input alu_op_class_e c);
      return (c == OP_ADD) || (c == OP_SUB) || (c == OP_ADC) ||
             (c == OP_SBC) || (c == OP_CMP);
   endfunction

   function automatic logic op_writes_back(input alu_op_class_e c);
      return (c != OP_CMP) && (c != OP_RSVD);
   endfunction
endpackage

// File: rtl/alu_flag_gen.sv
// Retire-side result selection and {N,Z,C,V} generation from the raw ALU outputs.
module alu_flag_gen
   import alu_pkg::*;
#(
   parameter int DATA_WIDTH = 64
) (
   input  alu_op_class_e         op_class,
   input  logic [DATA_WIDTH-1:0] alu_result,
   input  logic                  alu_carry,
   input  logic                  alu_overflow,
   output logic [DATA_WIDTH-1:0] result,
   output logic                  wb_en,
   output logic                  illegal,
   output logic [3:0]            flags
);
   logic [DATA_WIDTH-1:0] zn_value;

   always_comb begin
      wb_en    = op_writes_back(op_class);
      illegal  = (op_class == OP_RSVD);
      result   = wb_en ? alu_result : '0;
      // CMP discards its result but still reports N/Z of the difference
      zn_value = (op_class == OP_CMP) ? alu_result : result;
      flags         = '0;
      flags[FLAG_N] = zn_value[DATA_WIDTH-1];
      flags[FLAG_Z] = (zn_value == '0);
      if (op_uses_carry(op_class)) begin
         flags[FLAG_C] = alu_carry;
         flags[FLAG_V] = alu_overflow;
      end
   end
endmodule

// File: rtl/alu_issue_stage.sv
// Two-entry issue/retire stage around an external combinational ALU, with an
// architectural carry flag feeding ADC/SBC chains at full throughput.
module alu_issue_stage
   import alu_pkg::*;
#(
   parameter int DATA_WIDTH = 64,
   parameter int SHIFT_AMT  = $clog2(DATA_WIDTH)
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          flush,
   input  logic                          in_valid,
   output logic                          in_ready,
   input  logic [2:0]                    in_op_class,
   input  logic [SHIFT_OPCODE_WIDTH-1:0] in_shift_mode,
   input  logic [LOGIC_OPCODE_WIDTH-1:0] in_logic_opcode,
   input  logic [DATA_WIDTH-1:0]         in_a,
   input  logic [DATA_WIDTH-1:0]         in_b,
   input  logic [SHIFT_AMT-1:0]          in_shift_amt,
   output logic                          alu_add_sub_mode,
   output logic [SHIFT_OPCODE_WIDTH-1:0] alu_shift_mode,
   output logic [LOGIC_OPCODE_WIDTH-1:0] alu_logic_opcode,
   output logic [SHIFT_AMT-1:0]          alu_shift_amt,
   output logic [DATA_WIDTH-1:0]         alu_data_a,
   output logic [DATA_WIDTH-1:0]         alu_data_b,
   output logic                          alu_carry_in,
   input  logic [DATA_WIDTH-1:0]         alu_data_out,
   input  logic                          alu_carry_out,
   input  logic                          alu_overflow,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic [DATA_WIDTH-1:0]         out_data,
   output logic                          out_wb_en,
   output logic [3:0]                    out_flags,
   output logic                          out_illegal,
   output logic                          carry_flag
);
   alu_op_class_e         in_class, e_class;
   logic                  e_valid, e_carry_op;
   logic                  advance, accept, xfer;
   logic [DATA_WIDTH-1:0] fg_result;
   logic                  fg_wb_en, fg_illegal;
   logic [3:0]            fg_flags;

   assign in_class = alu_op_class_e'(in_op_class);
   assign advance  = !out_valid || out_ready;
   assign in_ready = !e_valid || advance;
   assign accept   = in_valid && in_ready;
   assign xfer     = e_valid && advance;

   // Live carry_flag lets an ADC entering E see its predecessor's carry with no bubble
   assign alu_carry_in = e_carry_op & carry_flag;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         e_valid          <= 1'b0;
         e_class          <= OP_ADD;
         e_carry_op       <= 1'b0;
         alu_add_sub_mode <= 1'b0;
         alu_shift_mode   <= '0;
         alu_logic_opcode <= '0;
         alu_shift_amt    <= '0;
         alu_data_a       <= '0;
         alu_data_b       <= '0;
      end else begin
         if (flush)        e_valid <= 1'b0;
         else if (accept)  e_valid <= 1'b1;
         else if (advance) e_valid <= 1'b0;
         if (accept && !flush) begin
            e_class          <= in_class;
            e_carry_op       <= (in_class == OP_ADC) || (in_class == OP_SBC);
            alu_add_sub_mode <= (in_class == OP_SUB) || (in_class == OP_SBC) ||
                                (in_class == OP_CMP);
            alu_shift_mode   <= in_shift_mode;
            alu_logic_opcode <= in_logic_opcode;
            alu_shift_amt    <= in_shift_amt;
            alu_data_a       <= in_a;
            alu_data_b       <= in_b;
         end
      end
   end

   alu_flag_gen #(.DATA_WIDTH(DATA_WIDTH)) u_flag_gen (
      .op_class     (e_class),
      .alu_result   (alu_data_out),
      .alu_carry    (alu_carry_out),
      .alu_overflow (alu_overflow),
      .result       (fg_result),
      .wb_en        (fg_wb_en),
      .illegal      (fg_illegal),
      .flags        (fg_flags)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid   <= 1'b0;
         out_data    <= '0;
         out_wb_en   <= 1'b0;
         out_flags   <= '0;
         out_illegal <= 1'b0;
         carry_flag  <= 1'b0;
      end else if (flush) begin
         out_valid  <= 1'b0;
         carry_flag <= 1'b0;
      end else begin
         if (advance) out_valid <= e_valid;
         if (xfer) begin
            out_data    <= fg_result;
            out_wb_en   <= fg_wb_en;
            out_flags   <= fg_flags;
            out_illegal <= fg_illegal;
            if (op_uses_carry(e_class)) carry_flag <= alu_carry_out;
         end
      end
   end
endmodule
